alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequential front-end that issues operations to the combinational 4-bit ALU and collects the results.
- Accepts commands (op, x, y) over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU's x/y/op inputs, waits a fixed settle time, then samples the ALU's o/cout.
- Returns each result in order over a valid/ready response interface, with an error flag for op codes the ALU does not implement.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries (power of 2, ≥2).
- SETTLE_CYCLES, 1: cycles alu_* are held before o/cout are sampled (≥1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  4  ALU op code
- cmd_x  in  4  operand x
- cmd_y  in  4  operand y
- alu_x  out  4  to ALU x
- alu_y  out  4  to ALU y
- alu_op  out  4  to ALU op
- alu_o  in  4  from ALU o
- alu_cout  in  1  from ALU cout
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  4  captured result
- rsp_cout  out  1  captured carry/borrow
- rsp_err  out  1  illegal op code
- busy  out  1  FSM not IDLE or FIFO non-empty
- cnt_issued  out  8  count of legal ops issued

Behaviour:
- Reset: when rst_n=0 at a clock edge, the following are cleared: FIFO (empty), FSM=IDLE, alu_x/alu_y/alu_op=0, rsp_valid/rsp_data/rsp_cout/rsp_err=0, cnt_issued=0, settle counter=0. Reset mid-operation discards the in-flight command and all queued commands.
- cmd_ready = !full, derived only from registered occupancy. A push when full is not accepted, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle leave occupancy unchanged. FIFO pointers wrap modulo FIFO_DEPTH.
- Legal ops are 4'b0001–4'b1011. Ops 4'b0000 and 4'b1100–4'b1111 are illegal.
- FSM states: IDLE, DRIVE, RESP.
- IDLE, FIFO empty: alu_op=0 and the FSM stays in IDLE.
- IDLE, FIFO non-empty: pop the head entry.
  - Legal op: register it onto alu_x/alu_y/alu_op, load the settle counter, increment cnt_issued (wraps 255→0), go to DRIVE.
  - Illegal op: alu_* unchanged, rsp_data=0, rsp_cout=0, rsp_err=1, rsp_valid=1, go to RESP.
- DRIVE: alu_* held stable. The counter decrements each cycle. On the SETTLE_CYCLES-th edge after entry, capture rsp_data=alu_o, rsp_cout=alu_cout, rsp_err=0, rsp_valid=1, go to RESP.
- RESP: rsp_* held stable while rsp_valid && !rsp_ready. On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
- One command is in flight at a time. Responses are returned in command order.
- Latency (empty FIFO, IDLE, SETTLE_CYCLES=1): command accepted at edge t; alu_* valid after edge t+1; rsp_valid high after edge t+2.
- Throughput with rsp_ready held high: one response per SETTLE_CYCLES+2 cycles.
- busy = (state≠IDLE) || !empty.

Optional Feature:
- Macro: ALU_ISSUE_CHAIN_EN.
- Defined:
  - Adds input port cmd_chain (1 bit), stored in the FIFO with each command.
  - For a legal op with cmd_chain=1, alu_x is driven from last_o instead of cmd_x.
  - last_o is an internal register: reset 0, updated to alu_o on every DRIVE capture, never updated by illegal ops.
- Undefined: no cmd_chain port, no last_o register; alu_x always comes from cmd_x.

Test Plan:
- Add, no carry: push op=0001 x=3 y=4, rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_data=7, rsp_cout=0, rsp_err=0, cnt_issued=1.
- Add with carry: push op=0001 x=9 y=8 → rsp_data=1, rsp_cout=1.
- Illegal ops: push op=0000 then op=1111 → two responses with rsp_err=1, rsp_data=0, rsp_cout=0; cnt_issued unchanged; alu_op unchanged.
- Backpressure: rsp_ready=0, push 6 AND commands back-to-back → 1 in flight, 4 queued, cmd_ready=0 on the 6th. Then raise rsp_ready → 6 responses returned in order, none lost or duplicated.
- Reset mid-op: rst_n=0 for one edge while in DRIVE with 3 queued → next cycle rsp_valid=0, busy=0, cnt_issued=0, cmd_ready=1; no stale response afterwards.
- Chain (ALU_ISSUE_CHAIN_EN defined): op=0001 x=2 y=3, then op=0001 chain=1 x=15 y=1 → second rsp_data=6. Counter wrap: 256 legal ops → cnt_issued=0.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Command and response handshake bundle between a requester and alu_issue_ctrl.
// cmd_chain is present only when ALU_ISSUE_CHAIN_EN is defined.
`timescale 1ns/1ps
interface alu_issue_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [3:0] cmd_x;
   logic [3:0] cmd_y;
`ifdef ALU_ISSUE_CHAIN_EN
   logic       cmd_chain;
`endif
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       rsp_cout;
   logic       rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y,
`ifdef ALU_ISSUE_CHAIN_EN
      output cmd_chain,
`endif
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_cout, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y,
`ifdef ALU_ISSUE_CHAIN_EN
      input  cmd_chain,
`endif
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_cout, rsp_err,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 4-bit ALU: command FIFO, IDLE/DRIVE/RESP sequencer, in-order responses.
// Define ALU_ISSUE_CHAIN_EN to add cmd_chain, which feeds the previous ALU result back as operand x.
`timescale 1ns/1ps
module alu_issue_ctrl #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   alu_issue_ctrl_if.slave        bus,
   output logic [3:0]             alu_x,
   output logic [3:0]             alu_y,
   output logic [3:0]             alu_op,
   input  logic [3:0]             alu_o,
   input  logic                   alu_cout,
   output logic                   busy,
   output logic [7:0]             cnt_issued
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES);

   typedef struct packed {
`ifdef ALU_ISSUE_CHAIN_EN
      logic       chain;
`endif
      logic [3:0] op;
      logic [3:0] x;
      logic [3:0] y;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   cmd_t             fifo_mem_q [FIFO_DEPTH];
   cmd_t             wr_entry_d;
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             full, empty, push, pop;

   state_t           state_q, state_d;
   logic [3:0]       alu_x_q, alu_x_d;
   logic [3:0]       alu_y_q, alu_y_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [3:0]       rsp_data_q, rsp_data_d;
   logic             rsp_cout_q, rsp_cout_d;
   logic             rsp_err_q, rsp_err_d;
`ifdef ALU_ISSUE_CHAIN_EN
   logic [3:0]       last_o_q, last_o_d;
`endif

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd11);
   endfunction

   assign full  = (occ_q == OCC_FULL);
   assign empty = (occ_q == '0);

   always_comb begin
      wr_entry_d    = '0;
      wr_entry_d.op = bus.cmd_op;
      wr_entry_d.x  = bus.cmd_x;
      wr_entry_d.y  = bus.cmd_y;
`ifdef ALU_ISSUE_CHAIN_EN
      wr_entry_d.chain = bus.cmd_chain;
`endif
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= wr_entry_d;
      end
   end

   always_comb begin
      head        = fifo_mem_q[rd_ptr_q];
      push        = bus.cmd_valid && !full;
      pop         = 1'b0;
      state_d     = state_q;
      alu_x_d     = alu_x_q;
      alu_y_d     = alu_y_q;
      alu_op_d    = alu_op_q;
      settle_d    = settle_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_err_d   = rsp_err_q;
`ifdef ALU_ISSUE_CHAIN_EN
      last_o_d    = last_o_q;
`endif

      case (state_q)
         IDLE: begin
            if (empty) begin
               alu_op_d = '0;
            end else begin
               pop = 1'b1;
               if (op_is_legal(head.op)) begin
`ifdef ALU_ISSUE_CHAIN_EN
                  alu_x_d = head.chain ? last_o_q : head.x;
`else
                  alu_x_d = head.x;
`endif
                  alu_y_d  = head.y;
                  alu_op_d = head.op;
                  settle_d = SET_LOAD;
                  cnt_d    = cnt_q + 8'd1;
                  state_d  = DRIVE;
               end else begin
                  // Illegal ops never reach the ALU; alu_* keep their last value.
                  rsp_data_d  = '0;
                  rsp_cout_d  = 1'b0;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end
            end
         end
         DRIVE: begin
            settle_d = settle_q - SET_W'(1);
            if (settle_q == SET_W'(1)) begin
               rsp_data_d  = alu_o;
               rsp_cout_d  = alu_cout;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
`ifdef ALU_ISSUE_CHAIN_EN
               last_o_d    = alu_o;
`endif
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         alu_x_q     <= '0;
         alu_y_q     <= '0;
         alu_op_q    <= '0;
         settle_q    <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
`ifdef ALU_ISSUE_CHAIN_EN
         last_o_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         alu_x_q     <= alu_x_d;
         alu_y_q     <= alu_y_d;
         alu_op_q    <= alu_op_d;
         settle_q    <= settle_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_err_q   <= rsp_err_d;
`ifdef ALU_ISSUE_CHAIN_EN
         last_o_q    <= last_o_d;
`endif
      end
   end

   assign bus.cmd_ready = !full;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.rsp_err   = rsp_err_q;
   assign alu_x         = alu_x_q;
   assign alu_y         = alu_y_q;
   assign alu_op        = alu_op_q;
   assign cnt_issued    = cnt_q;
   assign busy          = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed steps plus random traffic against a queue-based reference model.
// A behavioural ALU answers the DUT's alu_* outputs.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] alu_x, alu_y, alu_op, alu_o;
   logic       alu_cout, busy;
   logic [7:0] cnt_issued;
   int         checks = 0;
   int         errors = 0;
   bit         rand_ready = 1'b0;

   always #5 clk = ~clk;

   alu_issue_ctrl_if bus_if();

   alu_issue_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus_if),
      .alu_x      (alu_x),
      .alu_y      (alu_y),
      .alu_op     (alu_op),
      .alu_o      (alu_o),
      .alu_cout   (alu_cout),
      .busy       (busy),
      .cnt_issued (cnt_issued)
   );

   // Behavioural ALU: returns {cout, o}.
   function automatic logic [4:0] alu_ref(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
      int a, b;
      a = int'(x);
      b = int'(y);
      case (op)
         4'd1:    return 5'((a + b) & 31);
         4'd2:    return 5'((a - b) & 31);
         4'd3:    return {1'b0, x & y};
         4'd4:    return {1'b0, x | y};
         4'd5:    return {1'b0, x ^ y};
         4'd6:    return {1'b0, ~x};
         4'd7:    return 5'((a * 2) & 31);
         4'd8:    return {x[0], 4'(a / 2)};
         4'd9:    return 5'((a + 1) & 31);
         4'd10:   return 5'((a - 1) & 31);
         4'd11:   return {1'b0, y};
         default: return 5'd0;
      endcase
   endfunction

   assign {alu_cout, alu_o} = alu_ref(alu_op, alu_x, alu_y);

   function automatic bit is_legal(input logic [3:0] op);
      return (int'(op) >= 1) && (int'(op) <= 11);
   endfunction

   typedef struct {
      logic [3:0] op;
      logic [3:0] x;
      logic [3:0] y;
      logic       chain;
   } mcmd_t;

   mcmd_t      mq[$];
   mcmd_t      mc;
   logic [7:0] m_cnt = 8'd0;
   logic [3:0] m_last_o = 4'd0;
   logic [3:0] eff_x;
   logic [4:0] r5;
   logic [5:0] exp_rsp;
   int         n_rsp = 0;

   // Scoreboard: inputs are stable at the falling edge, so handshakes seen here complete on the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_cnt    = 8'd0;
         m_last_o = 4'd0;
      end else begin
         if (bus_if.rsp_valid && bus_if.rsp_ready) begin
            n_rsp++;
            checks++;
            assert (mq.size() > 0) else begin
               errors++;
               $error("FAIL rsp_spurious: got response data=%0h err=%0b, expected none", bus_if.rsp_data, bus_if.rsp_err);
            end
            if (mq.size() > 0) begin
               mc = mq.pop_front();
               if (is_legal(mc.op)) begin
                  eff_x    = mc.chain ? m_last_o : mc.x;
                  r5       = alu_ref(mc.op, eff_x, mc.y);
                  exp_rsp  = {1'b0, r5};
                  m_last_o = r5[3:0];
               end else begin
                  exp_rsp = 6'b100000;
               end
               checks++;
               assert ({bus_if.rsp_err, bus_if.rsp_cout, bus_if.rsp_data} === exp_rsp) else begin
                  errors++;
                  $error("FAIL rsp_data op=%0h x=%0h y=%0h: got {err,cout,data}=%0h expected %0h", mc.op, mc.x, mc.y,
                         {bus_if.rsp_err, bus_if.rsp_cout, bus_if.rsp_data}, exp_rsp);
               end
            end
         end
         if (bus_if.cmd_valid && bus_if.cmd_ready) begin
            mc.op = bus_if.cmd_op;
            mc.x  = bus_if.cmd_x;
            mc.y  = bus_if.cmd_y;
`ifdef ALU_ISSUE_CHAIN_EN
            mc.chain = bus_if.cmd_chain;
`else
            mc.chain = 1'b0;
`endif
            mq.push_back(mc);
            if (is_legal(mc.op)) m_cnt = m_cnt + 8'd1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
      bit acc;
      acc = 1'b0;
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = op;
      bus_if.cmd_x     = x;
      bus_if.cmd_y     = y;
      for (int k = 0; k < 200; k++) begin
         acc = bus_if.cmd_ready;
         step();
         if (acc) break;
      end
      bus_if.cmd_valid = 1'b0;
      if (!acc) check("send_accept", {31'd0, acc}, 32'd1);
   endtask

   task automatic wait_rsp();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (bus_if.rsp_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) check("rsp_wait", {31'd0, ok}, 32'd1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (!busy && !bus_if.rsp_valid && mq.size() == 0) begin
            done = 1'b1;
            break;
         end
         step();
      end
      check("drain_done", {31'd0, done}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   logic [3:0] rx, ry, rop;
   int         base_rsp;

   initial begin
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_op    = 4'd0;
      bus_if.cmd_x     = 4'd0;
      bus_if.cmd_y     = 4'd0;
`ifdef ALU_ISSUE_CHAIN_EN
      bus_if.cmd_chain = 1'b0;
`endif
      bus_if.rsp_ready = 1'b0;
      step();
      step();
      check("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
      check("rst_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cnt", {24'd0, cnt_issued}, 32'd0);
      check("rst_alu", {20'd0, alu_op, alu_x, alu_y}, 32'd0);
      check("rst_rsp_fields", {26'd0, bus_if.rsp_err, bus_if.rsp_cout, bus_if.rsp_data}, 32'd0);
      rst_n = 1'b1;
      step();

      // Latency: accept at edge t, alu_* after t+1, response after t+2.
      bus_if.rsp_ready = 1'b1;
      send(4'd1, 4'd3, 4'd4);
      check("lat_t0_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
      check("lat_t0_busy", {31'd0, busy}, 32'd1);
      step();
      check("lat_t1_alu", {20'd0, alu_op, alu_x, alu_y}, {20'd0, 4'd1, 4'd3, 4'd4});
      check("lat_t1_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
      step();
      check("lat_t2_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
      check("add_rsp", {26'd0, bus_if.rsp_err, bus_if.rsp_cout, bus_if.rsp_data}, 32'd7);
      check("add_cnt", {24'd0, cnt_issued}, 32'd1);
      step();
      drain();

      // Add with carry out.
      send(4'd1, 4'd9, 4'd8);
      wait_rsp();
      check("carry_rsp", {26'd0, bus_if.rsp_err, bus_if.rsp_cout, bus_if.rsp_data}, {26'd0, 1'b0, 1'b1, 4'd1});
      step();
      drain();
      check("carry_cnt", {24'd0, cnt_issued}, 32'd2);

      // Illegal ops queued behind a legal one leave alu_op and cnt_issued alone.
      send(4'd1, 4'd5, 4'd6);
      send(4'd0, 4'd7, 4'd7);
      send(4'd15, 4'd1, 4'd2);
      wait_rsp();
      check("ill_pre_rsp", {26'd0, bus_if.rsp_err, bus_if.rsp_cout, bus_if.rsp_data}, 32'd11);
      step();
      wait_rsp();
      check("ill0_rsp", {26'd0, bus_if.rsp_err, bus_if.rsp_cout, bus_if.rsp_data}, 32'h20);
      check("ill0_alu_op", {28'd0, alu_op}, 32'd1);
      step();
      wait_rsp();
      check("ill15_rsp", {26'd0, bus_if.rsp_err, bus_if.rsp_cout, bus_if.rsp_data}, 32'h20);
      check("ill15_alu_op", {28'd0, alu_op}, 32'd1);
      step();
      drain();
      check("ill_cnt", {24'd0, cnt_issued}, 32'd3);

      // Backpressure: one in flight, four queued, sixth refused.
      bus_if.rsp_ready = 1'b0;
      base_rsp = n_rsp;
      for (int i = 0; i < 5; i++) begin
         rx = 4'($urandom_range(0, 15));
         ry = 4'($urandom_range(0, 15));
         send(4'd3, rx, ry);
      end
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = 4'd3;
      bus_if.cmd_x     = rx;
      bus_if.cmd_y     = ry;
      check("bp_cmd_ready0", {31'd0, bus_if.cmd_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
      step();
      step();
      check("bp_cmd_ready1", {31'd0, bus_if.cmd_ready}, 32'd0);
      check("bp_no_rsp_yet", n_rsp - base_rsp, 32'd0);
      bus_if.rsp_ready = 1'b1;
      send(4'd3, rx, ry);
      drain();
      check("bp_rsp_count", n_rsp - base_rsp, 32'd6);
      check("bp_cnt", {24'd0, cnt_issued}, 32'd9);

      // Reset while DRIVE with three commands queued.
      bus_if.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(4'd1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      bus_if.rsp_ready = 1'b1;
      step();
      step();
      check("rm_drive_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
      check("rm_drive_alu_op", {28'd0, alu_op}, 32'd1);
      check("rm_drive_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rm_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
      check("rm_busy", {31'd0, busy}, 32'd0);
      check("rm_cnt", {24'd0, cnt_issued}, 32'd0);
      check("rm_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
      check("rm_alu_op", {28'd0, alu_op}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("rm_no_stale", {30'd0, bus_if.rsp_valid, busy}, 32'd0);
      end

`ifdef ALU_ISSUE_CHAIN_EN
      // Chaining: second add takes x from the first result.
      do_reset();
      bus_if.rsp_ready = 1'b1;
      bus_if.cmd_chain = 1'b0;
      send(4'd1, 4'd2, 4'd3);
      bus_if.cmd_chain = 1'b1;
      send(4'd1, 4'd15, 4'd1);
      bus_if.cmd_chain = 1'b0;
      wait_rsp();
      check("chain_first", {28'd0, bus_if.rsp_data}, 32'd5);
      step();
      wait_rsp();
      check("chain_second", {28'd0, bus_if.rsp_data}, 32'd6);
      step();
      drain();
`endif

      // Random traffic with random response backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         rop = 4'($urandom_range(0, 15));
         rx  = 4'($urandom_range(0, 15));
         ry  = 4'($urandom_range(0, 15));
`ifdef ALU_ISSUE_CHAIN_EN
         bus_if.cmd_chain = 1'($urandom_range(0, 1));
`endif
         send(rop, rx, ry);
         for (int g = $urandom_range(0, 2); g > 0; g--) step();
      end
`ifdef ALU_ISSUE_CHAIN_EN
      bus_if.cmd_chain = 1'b0;
`endif
      drain();
      rand_ready = 1'b0;
      bus_if.rsp_ready = 1'b1;
      check("rand_cnt", {24'd0, cnt_issued}, {24'd0, m_cnt});

      // cnt_issued wraps after 256 legal issues.
      do_reset();
      bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 256; i++) send(4'($urandom_range(1, 11)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drain();
      check("wrap_cnt", {24'd0, cnt_issued}, 32'd0);
      check("wrap_cnt_model", {24'd0, cnt_issued}, {24'd0, m_cnt});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
